var_delay_ctrl: RTL and testbench

- Run-time programmable sample delay with its own fill/lock sequencer, for aligning the I/Q branches and the carrier/symbol-timing paths of the PSK receiver when the alignment offset is only known after acquisition.
- Stores accepted samples in a circular buffer and emits the sample accepted D strobes earlier.
- Sequences refill after a delay change or flush.
- Accepts new delay values over a req/ack configuration handshake.

---
 rtl/var_delay_ctrl_pkg.sv | 16 +
 rtl/var_delay_ctrl_delay_ram.sv | 38 +++
 rtl/var_delay_ctrl.sv | 153 +++++++++++++++
 tb/tb_var_delay_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/var_delay_ctrl_pkg.sv
// Shared definitions for the programmable sample-delay block.
//   state_t   : sequencer states (ST_FILL, ST_RUN)
//   calc_aw() : address width for a power-of-2 buffer depth
package var_delay_ctrl_pkg;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // A depth of 2 still needs one address bit, so clamp at 1.
   function automatic int calc_aw(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/var_delay_ctrl_delay_ram.sv
// Read-first sample memory for the delay line.
// The read port has a combinational address and a registered output.
// Both ports are driven by the same sample strobe.
// A read of the location being written returns the old contents.
// There is no reset, so the memory can map onto distributed RAM or BRAM.
// Ports:
//   clk        clock
//   i_we       write enable
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_re       read enable (output register loads only when set)
//   i_rd_addr  read address
//   o_rd_data  registered read data
module delay_ram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_re,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_re) r_rd_data <= r_mem[i_rd_addr];
      if (i_we) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/var_delay_ctrl.sv
// Run-time programmable sample delay with fill/lock sequencing.
// Accepted samples go into a circular buffer.
// Each output is the sample accepted delay_cur strobes earlier.
// Delay is counted in strobes, not clocks.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   ST_FILL | fewer than delay_cur samples buffered; no output
//   ST_RUN  | buffer holds enough history; every strobe emits
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in_valid   sample strobe; I is accepted on cycles where this is 1
//   I          input sample
//   flush      one-cycle pulse that discards buffered history
//   cfg_req    level request to load cfg_delay
//   cfg_delay  requested delay (0..MAX_DELAY-1)
//   cfg_ack    one-cycle acceptance pulse
//   O          delayed sample (registered)
//   out_valid  one-cycle pulse; O is new this cycle
//   locked     1 while in ST_RUN
//   delay_cur  delay currently in effect
module var_delay_ctrl
   import var_delay_ctrl_pkg::*;
#(
   parameter  int WIDTH         = 16,
   parameter  int MAX_DELAY     = 64,
   parameter  int DEFAULT_DELAY = 1,
   localparam int AW            = calc_aw(MAX_DELAY)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] I,
   input  logic             flush,
   input  logic             cfg_req,
   input  logic [AW-1:0]    cfg_delay,
   output logic             cfg_ack,
   output logic [WIDTH-1:0] O,
   output logic             out_valid,
   output logic             locked,
   output logic [AW-1:0]    delay_cur
);

   state_t           r_state;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_fill;
   logic [AW-1:0]    r_delay_cur;
   logic             r_cfg_ack;
   logic             r_out_valid;
   logic             r_locked;
   logic             r_o_sel_ram;
   logic [WIDTH-1:0] r_o_byp;

   logic             w_accept;
   logic             w_cfg_accept;
   logic             w_emit;
   logic             w_delay_zero;
   logic [AW-1:0]    w_rd_addr;
   logic [WIDTH-1:0] w_ram_q;
   logic [AW-1:0]    w_fill_nxt;
   state_t           w_state_nxt;

   // A flush swallows a coincident strobe entirely: no write and no output.
   assign w_accept     = in_valid & ~flush;
   // The requester drops cfg_req in the ack cycle, so gating on cfg_ack
   // turns a two-cycle request into a single acceptance.
   assign w_cfg_accept = cfg_req & ~r_cfg_ack;
   assign w_emit       = w_accept & (r_fill >= r_delay_cur);
   assign w_delay_zero = (r_delay_cur == '0);
   // The buffer depth is a power of 2, so the AW-bit subtract wraps
   // modulo the buffer depth.
   assign w_rd_addr    = r_wr_ptr - r_delay_cur;

   delay_ram #(
      .WIDTH (WIDTH),
      .DEPTH (MAX_DELAY),
      .AW    (AW)
   ) u_delay_ram (
      .clk       (clk),
      .i_we      (w_accept),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (I),
      .i_re      (w_emit & ~w_delay_zero),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_ram_q)
   );

   // fill only advances while short of the delay.
   // It therefore never exceeds MAX_DELAY-1.
   always_comb begin
      w_fill_nxt = r_fill;
      if (flush)
         w_fill_nxt = '0;
      else if (w_accept && !w_emit)
         w_fill_nxt = r_fill + 1'b1;
   end

   // The sample in this cycle uses the old delay.
   // A coincident config change then decides the state with the new delay.
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = ST_FILL;
      end else begin
         if (w_emit)
            w_state_nxt = ST_RUN;
         if (w_cfg_accept)
            w_state_nxt = (cfg_delay <= w_fill_nxt) ? ST_RUN : ST_FILL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_FILL;
         r_locked    <= 1'b0;
         r_fill      <= '0;
         r_wr_ptr    <= '0;
         r_delay_cur <= AW'(DEFAULT_DELAY);
         r_cfg_ack   <= 1'b0;
         r_out_valid <= 1'b0;
         r_o_sel_ram <= 1'b0;
         r_o_byp     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_locked    <= (w_state_nxt == ST_RUN);
         r_fill      <= w_fill_nxt;
         r_cfg_ack   <= w_cfg_accept;
         r_out_valid <= w_emit;
         if (w_accept)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_cfg_accept)
            r_delay_cur <= cfg_delay;
         // Zero delay bypasses the memory.
         // A read-first RAM would return stale data at wr_ptr.
         if (w_emit) begin
            r_o_sel_ram <= ~w_delay_zero;
            if (w_delay_zero)
               r_o_byp <= I;
         end
      end
   end

   // Both O sources only change on an emitting strobe, so O holds in between.
   // The select resets to the bypass register, which gives O=0 out of reset
   // without clearing the RAM.
   assign O         = r_o_sel_ram ? w_ram_q : r_o_byp;
   assign out_valid = r_out_valid;
   assign cfg_ack   = r_cfg_ack;
   assign locked    = r_locked;
   assign delay_cur = r_delay_cur;

endmodule

// File: tb/tb_var_delay_ctrl.sv
module tb_var_delay_ctrl;

   localparam int W  = 16;
   localparam int MD = 64;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [W-1:0]  I = '0;
   logic          flush = 1'b0;
   logic          cfg_req = 1'b0;
   logic [AW-1:0] cfg_delay = '0;
   logic          cfg_ack;
   logic [W-1:0]  O;
   logic          out_valid;
   logic          locked;
   logic [AW-1:0] delay_cur;

   var_delay_ctrl #(.WIDTH(W), .MAX_DELAY(MD), .DEFAULT_DELAY(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .I         (I),
      .flush     (flush),
      .cfg_req   (cfg_req),
      .cfg_delay (cfg_delay),
      .cfg_ack   (cfg_ack),
      .O         (O),
      .out_valid (out_valid),
      .locked    (locked),
      .delay_cur (delay_cur)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] data;
      int unsigned  cyc;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         e;
   logic [W-1:0] hist[$];
   int           m_fill;
   int           m_delay;
   logic         m_locked;
   logic         m_ack;
   int           n_vec = 0;
   int           n_err = 0;
   int           ack_cnt;

   typedef struct {
      logic         v;
      logic [W-1:0] d;
      logic         lk;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
      end
   endtask

   // Scoreboard: compare every out_valid against the queued expectation
   // and flag expectations whose deadline passes without output.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL spurious_out_valid: got O=0x%0h expected no output at cycle %0d", O, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("O_data", int'(O), int'(e.data));
               chk("O_latency", int'(cyc), int'(e.cyc));
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL missing_out_valid: got none expected O=0x%0h at cycle %0d", exp_q[0].data, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1; in_valid = 0; flush = 0; cfg_req = 0; cfg_delay = '0; I = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_fill = 0; m_delay = 1; m_locked = 0; m_ack = 0;
      hist.delete();
      exp_q.delete();
      chk("rst_O", int'(O), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_cfg_ack", int'(cfg_ack), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_delay_cur", int'(delay_cur), 1);
   endtask

   // One clock of stimulus plus the reference model update for that clock.
   task automatic drive(input logic v, input logic [W-1:0] d, input logic f,
                        input logic cr, input int cd);
      logic acc;
      in_valid = v; I = d; flush = f; cfg_req = cr; cfg_delay = AW'(cd);
      acc = cr && !m_ack;
      if (f) begin
         m_fill = 0;
         m_locked = 0;
         hist.delete();
      end else if (v) begin
         hist.push_back(d);
         if (m_fill >= m_delay) begin
            exp_q.push_back('{hist[hist.size()-1-m_delay], cyc + 1});
            m_locked = 1;
         end else begin
            m_fill++;
         end
      end
      if (acc) begin
         m_delay = cd;
         if (!f) m_locked = (cd <= m_fill);
      end
      m_ack = acc;
      @(posedge clk);
      #1;
      in_valid = 0; flush = 0; cfg_req = 0;
      chk("locked", int'(locked), int'(m_locked));
      chk("cfg_ack", int'(cfg_ack), int'(m_ack));
      chk("delay_cur", int'(delay_cur), m_delay);
   endtask

   task automatic strobe(input logic [W-1:0] d);
      drive(1'b1, d, 1'b0, 1'b0, 0);
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, 1'b0, 0);
   endtask

   task automatic cfg(input int nd);
      drive(1'b0, '0, 1'b0, 1'b1, nd);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b1, 16'd1, 1'b0};
      tbl[1] = '{1'b1, 16'd2, 1'b1};
      tbl[2] = '{1'b1, 16'd3, 1'b1};
      tbl[3] = '{1'b0, 16'd0, 1'b1};
      tbl[4] = '{1'b1, 16'd4, 1'b1};
      tbl[5] = '{1'b1, 16'd5, 1'b1};
      tbl[6] = '{1'b1, 16'd6, 1'b1};
      tbl[7] = '{1'b0, 16'd0, 1'b1};

      do_reset();

      // Default delay 1: first strobe fills, then O = I-1.
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].v, tbl[i].d, 1'b0, 1'b0, 0);
         chk("tbl_locked", int'(locked), int'(tbl[i].lk));
      end

      // Delay 1 -> 5 with fill=1: four strobes unlocked, fifth emits.
      cfg(5);
      idle();
      for (int k = 0; k < 4; k++) begin
         strobe(W'(100 + k));
         chk("refill5_locked", int'(locked), 0);
      end
      strobe(W'(104));
      chk("refill5_lock_regained", int'(locked), 1);
      idle();

      // Delay 3, strobe every third clock.
      cfg(3);
      for (int k = 0; k < 9; k++) begin
         strobe(W'(200 + k));
         idle();
         idle();
      end

      // Delay 8 then down to 2 without losing lock.
      cfg(8);
      for (int k = 0; k < 6; k++) strobe(W'(300 + k));
      cfg(2);
      chk("shrink_keeps_lock", int'(locked), 1);
      for (int k = 0; k < 4; k++) strobe(W'(400 + k));

      // Flush with a coincident strobe: 0x7FFF must never appear.
      cfg(3);
      strobe(W'(450));
      drive(1'b1, 16'h7FFF, 1'b1, 1'b0, 0);
      chk("flush_locked", int'(locked), 0);
      for (int k = 0; k < 3; k++) strobe(W'(500 + k));
      chk("flush_refill_locked", int'(locked), 0);
      for (int k = 3; k < 6; k++) strobe(W'(500 + k));
      chk("flush_relock", int'(locked), 1);

      // Maximum delay across pointer wraps.
      cfg(MD - 1);
      for (int k = 0; k < 200; k++) strobe(W'(1000 + k));

      // Zero delay: O = I one clock later.
      cfg(0);
      for (int k = 0; k < 8; k++) begin
         strobe(W'(2000 + k));
         if (k % 3 == 0) idle();
      end

      // Flush, config and strobe in the same cycle.
      drive(1'b1, 16'h1234, 1'b1, 1'b1, 2);
      chk("flush_cfg_delay", int'(delay_cur), 2);
      for (int k = 0; k < 5; k++) strobe(W'(3000 + k));

      // Strobe coincident with acceptance uses the old delay (2).
      drive(1'b1, W'(3100), 1'b0, 1'b1, 4);
      chk("cfg_strobe_unlock", int'(locked), 0);
      for (int k = 0; k < 4; k++) strobe(W'(3200 + k));

      // cfg_req held two cycles: exactly one ack.
      ack_cnt = 0;
      drive(1'b0, '0, 1'b0, 1'b1, 7);
      if (cfg_ack) ack_cnt++;
      drive(1'b0, '0, 1'b0, 1'b1, 7);
      if (cfg_ack) ack_cnt++;
      idle();
      if (cfg_ack) ack_cnt++;
      chk("single_ack", ack_cnt, 1);
      for (int k = 0; k < 10; k++) strobe(W'(3300 + k));

      repeat (3) idle();
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
